// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use, branch-in-ID and mul/div stalls.
// Optional HAZARD_PERF_CNT_EN adds stall/flush performance counters.
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif

module hazard_ctrl #(
  parameter int         REG_ADDR_WIDTH = `REG_ADDR_WIDTH,
  parameter logic [6:0] BRANCH_OPCODE  = 7'b1100011,
  parameter logic [6:0] JALR_OPCODE    = 7'b1100111
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [6:0]                IF_ID_inst_opcode,
  input  logic [REG_ADDR_WIDTH-1:0] IF_ID_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] IF_ID_rs2,
  input  logic                      ID_EX_mem_rd_en,
  input  logic [REG_ADDR_WIDTH-1:0] ID_EX_rd,
  input  logic                      EX_MEM_mem_rd_en,
  input  logic [REG_ADDR_WIDTH-1:0] EX_MEM_rd,
  input  logic                      ID_EX_md_en,
  input  logic                      md_done,
  input  logic                      branch_taken,
  output logic                      md_start,
  output logic                      pc_wr_en,
  output logic                      IF_ID_wr_en,
  output logic                      ID_EX_wr_en,
  output logic                      IF_ID_flush,
  output logic                      ID_EX_flush,
  output logic                      EX_MEM_flush,
  output logic [31:0]               stall_cycles,
  output logic [31:0]               flush_count
);

  typedef enum logic [1:0] {
    RUN,
    BR_STALL,
    MD_WAIT
  } state_t;

  state_t state_q;
  state_t state_d;

  logic is_br;
  logic is_jalr;
  logic ex_ld;
  logic mem_ld;
  logic ex_rs1;
  logic ex_rs2;
  logic mem_rs1;
  logic mem_rs2;
  logic load_use;
  logic br_ex;
  logic br_mem;

  assign is_br   = IF_ID_inst_opcode == BRANCH_OPCODE;
  assign is_jalr = IF_ID_inst_opcode == JALR_OPCODE;

  assign ex_ld  = ID_EX_mem_rd_en && (ID_EX_rd != '0);
  assign mem_ld = EX_MEM_mem_rd_en && (EX_MEM_rd != '0);

  assign ex_rs1  = ex_ld && (ID_EX_rd == IF_ID_rs1);
  assign ex_rs2  = ex_ld && (ID_EX_rd == IF_ID_rs2);
  assign mem_rs1 = mem_ld && (EX_MEM_rd == IF_ID_rs1);
  assign mem_rs2 = mem_ld && (EX_MEM_rd == IF_ID_rs2);

  assign load_use = ex_rs1 | ex_rs2;
  // JALR only reads rs1, so rs2 matches never hold it for the branch path
  assign br_ex  = (is_br & (ex_rs1 | ex_rs2)) | (is_jalr & ex_rs1);
  assign br_mem = (is_br & (mem_rs1 | mem_rs2)) | (is_jalr & mem_rs1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    md_start     = 1'b0;
    pc_wr_en     = 1'b1;
    IF_ID_wr_en  = 1'b1;
    ID_EX_wr_en  = 1'b1;
    IF_ID_flush  = 1'b0;
    ID_EX_flush  = 1'b0;
    EX_MEM_flush = 1'b0;
    if (!rst_n) begin
      state_d = RUN;
    end else begin
      case (state_q)
        RUN: begin
          if (ID_EX_md_en) begin
            md_start     = 1'b1;
            pc_wr_en     = 1'b0;
            IF_ID_wr_en  = 1'b0;
            ID_EX_wr_en  = 1'b0;
            EX_MEM_flush = 1'b1;
            state_d      = MD_WAIT;
          end else if (br_ex) begin
            pc_wr_en    = 1'b0;
            IF_ID_wr_en = 1'b0;
            ID_EX_flush = 1'b1;
            state_d     = BR_STALL;
          end else if (load_use || br_mem) begin
            pc_wr_en    = 1'b0;
            IF_ID_wr_en = 1'b0;
            ID_EX_flush = 1'b1;
          end else if (branch_taken) begin
            IF_ID_flush = 1'b1;
          end
        end
        BR_STALL: begin
          pc_wr_en    = 1'b0;
          IF_ID_wr_en = 1'b0;
          ID_EX_flush = 1'b1;
          state_d     = RUN;
        end
        MD_WAIT: begin
          if (md_done) begin
            state_d = RUN;
          end else begin
            pc_wr_en     = 1'b0;
            IF_ID_wr_en  = 1'b0;
            ID_EX_wr_en  = 1'b0;
            EX_MEM_flush = 1'b1;
          end
        end
        default: begin
          state_d = RUN;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!pc_wr_en) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (IF_ID_flush) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cycles = stall_cnt_q;
  assign flush_count  = flush_cnt_q;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios then random
// traffic against a cycle-level behavioural reference model.
module tb_hazard_ctrl;

  localparam int         AW   = 5;
  localparam logic [6:0] BR   = 7'b1100011;
  localparam logic [6:0] JALR = 7'b1100111;
  localparam logic [6:0] ADD  = 7'b0110011;

  // {md_start, pc_wr, if_id_wr, id_ex_wr, if_id_fl, id_ex_fl, ex_mem_fl}
  localparam logic [6:0] O_DEF  = 7'b0_111_000;
  localparam logic [6:0] O_STL  = 7'b0_001_010;
  localparam logic [6:0] O_MDS  = 7'b1_000_001;
  localparam logic [6:0] O_MDW  = 7'b0_000_001;
  localparam logic [6:0] O_TAKE = 7'b0_111_100;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [6:0]    opcode;
  logic [AW-1:0] rs1, rs2, ex_rd, mem_rd;
  logic          ex_ld, mem_ld, md_en, md_done, taken;
  logic          md_start, pc_wr_en, if_id_wr_en, id_ex_wr_en;
  logic          if_id_flush, id_ex_flush, ex_mem_flush;
  logic [31:0]   stall_cycles, flush_count;

  int checks = 0;
  int errors = 0;

  int          br_left;
  bit          md_wait;
  int          n_br;
  bit          n_md;
  logic [6:0]  exp_o;
  logic [31:0] m_stall;
  logic [31:0] m_flush;

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_ADDR_WIDTH(AW)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .IF_ID_inst_opcode(opcode),
    .IF_ID_rs1        (rs1),
    .IF_ID_rs2        (rs2),
    .ID_EX_mem_rd_en  (ex_ld),
    .ID_EX_rd         (ex_rd),
    .EX_MEM_mem_rd_en (mem_ld),
    .EX_MEM_rd        (mem_rd),
    .ID_EX_md_en      (md_en),
    .md_done          (md_done),
    .branch_taken     (taken),
    .md_start         (md_start),
    .pc_wr_en         (pc_wr_en),
    .IF_ID_wr_en      (if_id_wr_en),
    .ID_EX_wr_en      (id_ex_wr_en),
    .IF_ID_flush      (if_id_flush),
    .ID_EX_flush      (id_ex_flush),
    .EX_MEM_flush     (ex_mem_flush),
    .stall_cycles     (stall_cycles),
    .flush_count      (flush_count)
  );

  task automatic drive(input logic [6:0] op, input int a1, input int a2,
                       input bit el, input int er, input bit ml,
                       input int mr, input bit me, input bit md,
                       input bit tk);
    opcode  = op;
    rs1     = AW'(a1);
    rs2     = AW'(a2);
    ex_ld   = el;
    ex_rd   = AW'(er);
    mem_ld  = ml;
    mem_rd  = AW'(mr);
    md_en   = me;
    md_done = md;
    taken   = tk;
  endtask

  task automatic idle();
    drive(ADD, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Reference: expected outputs from the hazard rules for this cycle
  task automatic eval();
    bit hit_ex1, hit_ex2, hit_m1, hit_m2, isb, isj;
    exp_o = O_DEF;
    n_br  = br_left;
    n_md  = md_wait;
    isb = opcode == BR;
    isj = opcode == JALR;
    hit_ex1 = ex_ld && ex_rd != 0 && ex_rd == rs1;
    hit_ex2 = ex_ld && ex_rd != 0 && ex_rd == rs2;
    hit_m1  = mem_ld && mem_rd != 0 && mem_rd == rs1;
    hit_m2  = mem_ld && mem_rd != 0 && mem_rd == rs2;
    if (!rst_n) begin
      n_br = 0;
      n_md = 0;
      m_stall = 0;
      m_flush = 0;
    end else if (md_wait) begin
      if (md_done) n_md = 0;
      else exp_o = O_MDW;
    end else if (br_left > 0) begin
      exp_o = O_STL;
      n_br = br_left - 1;
    end else if (md_en) begin
      exp_o = O_MDS;
      n_md = 1;
    end else if ((isb && (hit_ex1 || hit_ex2)) || (isj && hit_ex1)) begin
      exp_o = O_STL;
      n_br = 1;
    end else if (hit_ex1 || hit_ex2 ||
                 (isb && (hit_m1 || hit_m2)) || (isj && hit_m1)) begin
      exp_o = O_STL;
    end else if (taken) begin
      exp_o = O_TAKE;
    end
  endtask

  task automatic check(input string tag);
    logic [6:0]  obs;
    logic [31:0] es, ef;
    obs = {md_start, pc_wr_en, if_id_wr_en, id_ex_wr_en,
           if_id_flush, id_ex_flush, ex_mem_flush};
`ifdef HAZARD_PERF_CNT_EN
    es = m_stall;
    ef = m_flush;
`else
    es = 0;
    ef = 0;
`endif
    checks++;
    assert (obs === exp_o) else begin
      errors++;
      $error("FAIL %s ctrl obs=%b exp=%b", tag, obs, exp_o);
    end
    checks++;
    assert (stall_cycles === es) else begin
      errors++;
      $error("FAIL %s stall_cycles obs=%0d exp=%0d", tag, stall_cycles, es);
    end
    checks++;
    assert (flush_count === ef) else begin
      errors++;
      $error("FAIL %s flush_count obs=%0d exp=%0d", tag, flush_count, ef);
    end
  endtask

  // Called just after a falling edge with inputs already driven
  task automatic cycle(input string tag);
    #1;
    eval();
    check(tag);
    @(posedge clk);
    br_left = n_br;
    md_wait = n_md;
    if (rst_n) begin
      if (!exp_o[5]) m_stall = m_stall + 32'd1;
      if (exp_o[2])  m_flush = m_flush + 32'd1;
    end
    @(negedge clk);
  endtask

  initial begin
    br_left = 0;
    md_wait = 0;
    m_stall = 0;
    m_flush = 0;
    idle();
    @(negedge clk);
    cycle("reset_idle");
    drive(BR, 5, 0, 1, 5, 0, 0, 1, 0, 1);
    cycle("reset_busy");
    idle();
    rst_n = 1'b1;
    cycle("post_reset");

    drive(ADD, 5, 0, 1, 5, 0, 0, 0, 0, 0);
    cycle("ld_use");
    drive(ADD, 5, 0, 0, 0, 1, 5, 0, 0, 0);
    cycle("ld_use_after");

    drive(BR, 1, 7, 1, 7, 0, 0, 0, 0, 0);
    cycle("br_ex_0");
    drive(BR, 1, 7, 0, 0, 1, 7, 0, 0, 1);
    cycle("br_ex_1");
    drive(BR, 1, 7, 0, 0, 0, 0, 0, 0, 0);
    cycle("br_ex_done");
    drive(BR, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    cycle("br_x0");
    drive(BR, 3, 2, 0, 0, 1, 3, 0, 0, 0);
    cycle("br_mem");
    drive(JALR, 4, 6, 0, 0, 1, 6, 0, 0, 0);
    cycle("jalr_rs2_mem");
    idle();
    md_done = 1'b1;
    cycle("md_done_ign");

    drive(ADD, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    cycle("md_start");
    for (int i = 0; i < 5; i++) begin
      drive(ADD, 0, 0, 0, 0, 0, 0, 1, 0, i == 2);
      cycle("md_wait");
    end
    drive(ADD, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    cycle("md_release");
    idle();
    cycle("md_after");

    drive(ADD, 9, 0, 1, 9, 0, 0, 0, 0, 1);
    cycle("take_stall");
    drive(BR, 9, 0, 0, 0, 0, 0, 0, 0, 1);
    cycle("take_flush");
    idle();
    cycle("take_after");

    drive(ADD, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    cycle("rst_md_start");
    cycle("rst_md_w1");
    rst_n = 1'b0;
    md_en = 1'b0;
    cycle("rst_md_w2");
    rst_n = 1'b1;
    cycle("rst_md_post");
    cycle("rst_md_post2");

    drive(BR, 8, 0, 1, 8, 0, 0, 0, 0, 0);
    cycle("rst_br_0");
    rst_n = 1'b0;
    idle();
    cycle("rst_br_1");
    rst_n = 1'b1;
    cycle("rst_br_post");

`ifdef HAZARD_PERF_CNT_EN
    dut.stall_cnt_q = 32'hFFFF_FFFF;
    m_stall = 32'hFFFF_FFFF;
    drive(ADD, 4, 0, 1, 4, 0, 0, 0, 0, 0);
    cycle("wrap_stall");
    idle();
    cycle("wrap_after");
`endif

    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 2) == 0) ? ADD :
            (($urandom_range(0, 1) == 0) ? BR : JALR),
            $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 1) == 1, $urandom_range(0, 3),
            $urandom_range(0, 1) == 1, $urandom_range(0, 3),
            $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 2) == 0);
      rst_n = $urandom_range(0, 49) != 0;
      cycle("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
